// File: rtl/optflow_pkg.sv
// Shared widths, filter taps and FSM encoding for the optical-flow gradient
// weighting stages.
package optflow_pkg;
  localparam int DATA_W = 32;
  localparam int COEF_W = 16;
  localparam int TAPS   = 7;
  localparam int PROD_W = DATA_W + COEF_W + 1;
  localparam int ACC_W  = PROD_W + 3;

  localparam logic [COEF_W-1:0] GRAD_FILTER [0:TAPS-1] = '{
    16'd4948, 16'd8716, 16'd12249, 16'd19025, 16'd12249, 16'd8716, 16'd4948
  };

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FILL  = 3'd1,
    RUN   = 3'd2,
    FLUSH = 3'd3,
    DRAIN = 3'd4
  } state_t;
endpackage

// File: rtl/grad_fir7_mac.sv
// Combinational 7-tap weighting MAC: win[0] is the oldest sample, win[6] the
// newest; the Q0.16 result is floored and clamped to the signed 32-bit range.
module grad_fir7_mac
  import optflow_pkg::*;
#(
  parameter int COEF_FRAC = 16
) (
  input  logic [TAPS-1:0][DATA_W-1:0] win,
  output logic [DATA_W-1:0]           result
);
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(signed'(32'h7FFF_FFFF));
  localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(signed'(32'h8000_0000));

  logic signed [PROD_W-1:0] prod_s;
  logic signed [ACC_W-1:0]  acc_s;
  logic signed [ACC_W-1:0]  shifted_s;

  // Accumulate signed-sample x unsigned-coefficient products, rescale, clamp.
  always_comb begin
    acc_s  = '0;
    prod_s = '0;
    for (int k = 0; k < TAPS; k++) begin
      prod_s = PROD_W'(signed'(win[k])) * signed'(PROD_W'({1'b0, GRAD_FILTER[k]}));
      acc_s  = acc_s + ACC_W'(prod_s);
    end
    shifted_s = acc_s >>> COEF_FRAC;
    if (shifted_s > SAT_MAX) begin
      result = 32'h7FFF_FFFF;
    end else if (shifted_s < SAT_MIN) begin
      result = 32'h8000_0000;
    end else begin
      result = shifted_s[DATA_W-1:0];
    end
  end
endmodule

// File: rtl/gradient_weight_x_2.sv
// Horizontal 7-tap gradient weighting over a raster stream with zero padding
// at row edges; vld/ack handshakes on both sides, registered output word.
module gradient_weight_x_2
  import optflow_pkg::*;
#(
  parameter int WIDTH     = 1024,
  parameter int HEIGHT    = 436,
  parameter int COEF_FRAC = 16
) (
  input  logic              ap_clk,
  input  logic              ap_rst,
  input  logic              ap_start,
  output logic              ap_done,
  output logic              ap_idle,
  output logic              ap_ready,
  input  logic [DATA_W-1:0] Input_1_V_V,
  input  logic              Input_1_V_V_ap_vld,
  output logic              Input_1_V_V_ap_ack,
  output logic [DATA_W-1:0] Output_1_V_V,
  output logic              Output_1_V_V_ap_vld,
  input  logic              Output_1_V_V_ap_ack
);
  localparam int S_W = $clog2(WIDTH + 3);
  localparam int R_W = $clog2(HEIGHT + 1);

  state_t                      state_r, state_s;
  logic [S_W-1:0]              step_r, step_s;
  logic [R_W-1:0]              row_r, row_s;
  logic [TAPS-1:0][DATA_W-1:0] win_r, win_s;
  logic [DATA_W-1:0]           out_data_r, mac_s, sample_s;
  logic                        out_vld_r;
  logic                        active_s, flushing_s, fire_s, done_s;

  grad_fir7_mac #(.COEF_FRAC(COEF_FRAC)) u_mac (
    .win    (win_s),
    .result (mac_s)
  );

  // Step fire decode and post-shift window; step 0 starts from a zero window.
  always_comb begin
    active_s   = (state_r == FILL) || (state_r == RUN) || (state_r == FLUSH);
    flushing_s = (step_r >= S_W'(WIDTH));
    fire_s     = active_s && (flushing_s || Input_1_V_V_ap_vld) &&
                 ((step_r < S_W'(3)) || !out_vld_r || Output_1_V_V_ap_ack);
    if (flushing_s) begin
      sample_s = '0;
    end else begin
      sample_s = Input_1_V_V;
    end
    if (step_r == '0) begin
      win_s = {sample_s, {((TAPS-1)*DATA_W){1'b0}}};
    end else begin
      win_s = {sample_s, win_r[TAPS-1:1]};
    end
  end

  // Next-state, step and row counters.
  always_comb begin
    state_s = state_r;
    step_s  = step_r;
    row_s   = row_r;
    done_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (ap_start) begin
          state_s = FILL;
          step_s  = '0;
          row_s   = '0;
        end else begin
          state_s = IDLE;
        end
      end
      FILL, RUN, FLUSH: begin
        if (fire_s) begin
          step_s = step_r + S_W'(1);
          if (step_r == S_W'(2)) begin
            state_s = RUN;
          end else if (step_r == S_W'(WIDTH - 1)) begin
            state_s = FLUSH;
          end else if (step_r == S_W'(WIDTH + 2)) begin
            step_s = '0;
            if (row_r == R_W'(HEIGHT - 1)) begin
              state_s = DRAIN;
            end else begin
              row_s   = row_r + R_W'(1);
              state_s = FILL;
            end
          end else begin
            state_s = state_r;
          end
        end else begin
          state_s = state_r;
        end
      end
      DRAIN: begin
        if (out_vld_r && Output_1_V_V_ap_ack) begin
          done_s  = 1'b1;
          state_s = IDLE;
        end else begin
          state_s = DRAIN;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State, window and output register; a new step may overwrite an acked word.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state_r    <= IDLE;
      step_r     <= '0;
      row_r      <= '0;
      win_r      <= '0;
      out_data_r <= '0;
      out_vld_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      step_r  <= step_s;
      row_r   <= row_s;
      if (fire_s) begin
        win_r <= win_s;
      end
      if (fire_s && (step_r >= S_W'(3))) begin
        out_data_r <= mac_s;
        out_vld_r  <= 1'b1;
      end else if (Output_1_V_V_ap_ack) begin
        out_vld_r  <= 1'b0;
      end
    end
  end

  assign Input_1_V_V_ap_ack  = fire_s && !flushing_s;
  assign ap_ready            = Input_1_V_V_ap_ack && (row_r == R_W'(HEIGHT - 1)) &&
                               (step_r == S_W'(WIDTH - 1));
  assign ap_done             = done_s;
  assign ap_idle             = (state_r == IDLE);
  assign Output_1_V_V        = out_data_r;
  assign Output_1_V_V_ap_vld = out_vld_r;
endmodule

// File: tb/tb_gradient_weight_x_2.sv
// Scoreboard bench for gradient_weight_x_2 at WIDTH=8, HEIGHT=2: expected words
// are queued as each frame is set up and compared against accepted outputs.
module tb_gradient_weight_x_2;
  localparam int W = 8;
  localparam int H = 2;
  localparam int N = W * H;

  logic        ap_clk = 1'b0;
  logic        ap_rst, ap_start, ap_done, ap_idle, ap_ready;
  logic [31:0] in_data, out_data;
  logic        in_vld, in_ack, out_vld, out_ack;

  int coef       [7] = '{4948, 8716, 12249, 19025, 12249, 8716, 4948};
  int impulse_exp[8] = '{4948, 8716, 12249, 19025, 12249, 8716, 4948, 0};
  int const_exp  [8] = '{44938, 57187, 65903, 70851, 70851, 65903, 57187, 44938};

  int frame [N];
  int exp_q[$];
  int got_q[$];
  int passed = 0, total = 0;
  int in_cnt, ready_cnt, ready_idx, done_cnt, done_at, hold_viol, stall_in_acks;
  bit timed_out;

  gradient_weight_x_2 #(.WIDTH(W), .HEIGHT(H), .COEF_FRAC(16)) dut (
    .ap_clk              (ap_clk),
    .ap_rst              (ap_rst),
    .ap_start            (ap_start),
    .ap_done             (ap_done),
    .ap_idle             (ap_idle),
    .ap_ready            (ap_ready),
    .Input_1_V_V         (in_data),
    .Input_1_V_V_ap_vld  (in_vld),
    .Input_1_V_V_ap_ack  (in_ack),
    .Output_1_V_V        (out_data),
    .Output_1_V_V_ap_vld (out_vld),
    .Output_1_V_V_ap_ack (out_ack)
  );

  always #5 ap_clk = ~ap_clk;

  function automatic int model(int r, int c);
    longint acc = 0;
    for (int k = 0; k < 7; k++) begin
      int j = c + k - 3;
      if (j >= 0 && j < W) acc += longint'(frame[r * W + j]) * longint'(coef[k]);
    end
    acc = acc >>> 16;
    if (acc > 64'sd2147483647) return 32'h7FFF_FFFF;
    if (acc < -64'sd2147483648) return 32'h8000_0000;
    return int'(acc);
  endfunction

  // vld_mode: 0 always valid, 1 alternating, 2 random. stall_at: output count
  // at which ack drops for 5 cycles (-1 none). abort_at: input count to stop at.
  task automatic run_frame(input int vld_mode, input int stall_at, input int abort_at);
    int          stall_left = 0;
    bit          stalled = 1'b0;
    bit          hold_pending = 1'b0;
    logic [31:0] held = '0;
    int          tail = 0;
    in_cnt = 0; ready_cnt = 0; ready_idx = -1; done_cnt = 0; done_at = -1;
    hold_viol = 0; stall_in_acks = 0; timed_out = 1'b1;
    got_q.delete();
    for (int cyc = 0; cyc < 300; cyc++) begin
      @(negedge ap_clk);
      ap_start = (cyc == 0);
      case (vld_mode)
        0:       in_vld = (in_cnt < N);
        1:       in_vld = (in_cnt < N) && (cyc % 2 == 0);
        default: in_vld = (in_cnt < N) && ($urandom_range(0, 1) == 1);
      endcase
      if (in_vld) in_data = frame[in_cnt];
      else        in_data = 32'hDEAD_BEEF;
      if (!stalled && stall_at >= 0 && got_q.size() == stall_at) begin
        stalled = 1'b1;
        stall_left = 5;
      end
      out_ack = (stall_left == 0);
      #1;
      if (abort_at >= 0 && in_cnt == abort_at) begin
        timed_out = 1'b0;
        break;
      end
      if (hold_pending && (!out_vld || out_data !== held)) hold_viol++;
      hold_pending = out_vld && !out_ack;
      held = out_data;
      if (out_vld && !out_ack && in_ack) stall_in_acks++;
      if (stall_left > 0) stall_left--;
      if (ap_ready) begin ready_cnt++; ready_idx = in_cnt + 1; end
      if (in_vld && in_ack) in_cnt++;
      if (out_vld && out_ack) got_q.push_back(int'(out_data));
      if (ap_done) begin done_cnt++; done_at = got_q.size(); end
      if (done_cnt > 0) tail++;
      if (tail > 3) begin
        timed_out = 1'b0;
        break;
      end
    end
    in_vld = 1'b0;
    out_ack = 1'b1;
    ap_start = 1'b0;
  endtask

  task automatic test_reset();
    ap_rst = 1'b1; ap_start = 1'b0; in_vld = 1'b1; in_data = 32'h1234_5678; out_ack = 1'b1;
    repeat (3) @(negedge ap_clk);
    #1;
    total++; if (out_vld !== 1'b0) $display("FAIL reset out_vld: got %b expected 0", out_vld); else passed++;
    total++; if (out_data !== 32'h0) $display("FAIL reset out_data: got %h expected 0", out_data); else passed++;
    total++; if (in_ack !== 1'b0) $display("FAIL reset in_ack: got %b expected 0", in_ack); else passed++;
    total++; if ({ap_done, ap_ready} !== 2'b00) $display("FAIL reset done/ready: got %b expected 00", {ap_done, ap_ready}); else passed++;
    @(negedge ap_clk);
    ap_rst = 1'b0;
    @(negedge ap_clk);
    #1;
    total++; if (ap_idle !== 1'b1) $display("FAIL reset ap_idle: got %b expected 1", ap_idle); else passed++;
    total++; if (in_ack !== 1'b0) $display("FAIL idle no-start in_ack: got %b expected 0", in_ack); else passed++;
    in_vld = 1'b0;
  endtask

  task automatic test_impulse(input string tag);
    int g, e;
    foreach (frame[i]) frame[i] = 0;
    frame[3] = 32'h0001_0000;
    for (int i = 0; i < N; i++) exp_q.push_back(i < W ? impulse_exp[i] : 0);
    run_frame(0, -1, -1);
    total++; if (timed_out) $display("FAIL %s timeout: got %0d outputs expected %0d", tag, got_q.size(), N); else passed++;
    total++; if (got_q.size() !== N) $display("FAIL %s count: got %0d expected %0d", tag, got_q.size(), N); else passed++;
    for (int i = 0; got_q.size() > 0 && exp_q.size() > 0; i++) begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      total++; if (g !== e) $display("FAIL %s out[%0d]: got %0d expected %0d", tag, i, g, e); else passed++;
    end
    exp_q.delete();
  endtask

  task automatic test_constant();
    int g, e;
    foreach (frame[i]) frame[i] = 32'h0001_0000;
    for (int i = 0; i < N; i++) exp_q.push_back(const_exp[i % W]);
    run_frame(0, -1, -1);
    total++; if (got_q.size() !== N) $display("FAIL const count: got %0d expected %0d", got_q.size(), N); else passed++;
    for (int i = 0; got_q.size() > 0 && exp_q.size() > 0; i++) begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      total++; if (g !== e) $display("FAIL const out[%0d]: got %0d expected %0d", i, g, e); else passed++;
    end
    exp_q.delete();
    total++; if (ready_cnt !== 1) $display("FAIL const ap_ready pulses: got %0d expected 1", ready_cnt); else passed++;
    total++; if (ready_idx !== N) $display("FAIL const ap_ready input: got %0d expected %0d", ready_idx, N); else passed++;
    total++; if (done_cnt !== 1) $display("FAIL const ap_done pulses: got %0d expected 1", done_cnt); else passed++;
    total++; if (done_at !== N) $display("FAIL const ap_done output: got %0d expected %0d", done_at, N); else passed++;
  endtask

  task automatic test_saturation();
    int g, e;
    int vals[2] = '{32'h7FFF_FFFF, 32'h8000_0000};
    for (int p = 0; p < 2; p++) begin
      foreach (frame[i]) frame[i] = vals[p];
      for (int i = 0; i < N; i++) exp_q.push_back(model(i / W, i % W));
      run_frame(0, -1, -1);
      total++; if (got_q.size() !== N) $display("FAIL sat%0d count: got %0d expected %0d", p, got_q.size(), N); else passed++;
      for (int i = 0; got_q.size() > 0 && exp_q.size() > 0; i++) begin
        g = got_q.pop_front(); e = exp_q.pop_front();
        total++; if (g !== e) $display("FAIL sat%0d out[%0d]: got %h expected %h", p, i, g, e); else passed++;
      end
      exp_q.delete();
    end
  endtask

  task automatic test_backpressure();
    int g, e;
    foreach (frame[i]) frame[i] = 32'h0001_0000;
    for (int i = 0; i < N; i++) exp_q.push_back(const_exp[i % W]);
    run_frame(0, 3, -1);
    total++; if (got_q.size() !== N) $display("FAIL bp count: got %0d expected %0d", got_q.size(), N); else passed++;
    for (int i = 0; got_q.size() > 0 && exp_q.size() > 0; i++) begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      total++; if (g !== e) $display("FAIL bp out[%0d]: got %0d expected %0d", i, g, e); else passed++;
    end
    exp_q.delete();
    total++; if (hold_viol !== 0) $display("FAIL bp hold: got %0d changes expected 0", hold_viol); else passed++;
    total++; if (stall_in_acks !== 0) $display("FAIL bp input acks while full: got %0d expected 0", stall_in_acks); else passed++;
  endtask

  task automatic test_starvation();
    int g, e;
    foreach (frame[i]) frame[i] = 32'h0001_0000;
    for (int i = 0; i < N; i++) exp_q.push_back(const_exp[i % W]);
    run_frame(1, -1, -1);
    total++; if (got_q.size() !== N) $display("FAIL starve count: got %0d expected %0d", got_q.size(), N); else passed++;
    for (int i = 0; got_q.size() > 0 && exp_q.size() > 0; i++) begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      total++; if (g !== e) $display("FAIL starve out[%0d]: got %0d expected %0d", i, g, e); else passed++;
    end
    exp_q.delete();
    total++; if (done_cnt !== 1) $display("FAIL starve ap_done pulses: got %0d expected 1", done_cnt); else passed++;
  endtask

  task automatic test_random();
    int g, e;
    foreach (frame[i]) frame[i] = int'($urandom());
    for (int i = 0; i < N; i++) exp_q.push_back(model(i / W, i % W));
    run_frame(2, -1, -1);
    total++; if (got_q.size() !== N) $display("FAIL rand count: got %0d expected %0d", got_q.size(), N); else passed++;
    for (int i = 0; got_q.size() > 0 && exp_q.size() > 0; i++) begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      total++; if (g !== e) $display("FAIL rand out[%0d]: got %h expected %h", i, g, e); else passed++;
    end
    exp_q.delete();
  endtask

  task automatic test_mid_reset();
    foreach (frame[i]) frame[i] = 32'h0001_0000;
    run_frame(0, -1, W + 4);
    ap_rst = 1'b1;
    repeat (2) @(negedge ap_clk);
    ap_rst = 1'b0;
    @(negedge ap_clk);
    #1;
    total++; if (ap_idle !== 1'b1) $display("FAIL midreset ap_idle: got %b expected 1", ap_idle); else passed++;
    total++; if (out_vld !== 1'b0) $display("FAIL midreset out_vld: got %b expected 0", out_vld); else passed++;
    total++; if (out_data !== 32'h0) $display("FAIL midreset out_data: got %h expected 0", out_data); else passed++;
    test_impulse("post-reset impulse");
  endtask

  initial begin
    test_reset();
    test_impulse("impulse");
    test_constant();
    test_saturation();
    test_backpressure();
    test_starvation();
    test_random();
    test_mid_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d so far", passed, total);
    $fatal(1);
  end
endmodule
